// File: rtl/uart_tx_fifo_serializer.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_serializer
//
// Transmit side of the APB UART. Bytes pushed by the APB interface are held
// in a small synchronous FIFO and shifted out on tx_serial as 8N1 frames
// (8E1 when parity is enabled), LSB first, at CLKS_PER_BIT pclk cycles per
// bit. Full/empty status feeds the APB side's PREADY generation.
//
// Build option:
//   UART_TX_PARITY_EN  - when defined, an even-parity bit is sent between the
//                        last data bit and the stop bit(s).
//
// Parameters:
//   DEPTH         FIFO entries (power of 2, >= 2)
//   CLKS_PER_BIT  pclk cycles per UART bit (>= 2)
//   STOP_BITS     1 or 2
//
// Ports:
//   pclk             in   clock
//   PRESETn          in   asynchronous reset, active high
//   tx_fifo_writeEn  in   push request, only its rising edge pushes
//   tx_fifo_dataIn   in   byte to push (sampled on the writeEn rising edge)
//   tx_fifo_Full     out  FIFO full
//   tx_fifo_Empty    out  FIFO empty
//   tx_fifo_count    out  FIFO occupancy
//   tx_overflow      out  one-cycle pulse when a push hits a full FIFO
//   tx_serial        out  UART line, idles high, registered
//   tx_busy          out  high while a frame is in progress
//
// FSM states:
//   state    | meaning
//   S_IDLE   | line high; pops the next byte when the FIFO is not empty
//   S_START  | start bit (low) for one bit time
//   S_DATA   | data bits 0..7, LSB first
//   S_PARITY | even parity of the data byte (parity builds only)
//   S_STOP   | line high for STOP_BITS bit times
// ----------------------------------------------------------------------------
module uart_tx_fifo_serializer #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic                    pclk,
    input  logic                    PRESETn,
    input  logic                    tx_fifo_writeEn,
    input  logic [7:0]              tx_fifo_dataIn,
    output logic                    tx_fifo_Full,
    output logic                    tx_fifo_Empty,
    output logic [$clog2(DEPTH):0]  tx_fifo_count,
    output logic                    tx_overflow,
    output logic                    tx_serial,
    output logic                    tx_busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_RELOAD = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_wen_d;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;

    // Full is taken from the current pointers, so a pop in the same cycle
    // cannot make room for a push that arrives while full.
    assign w_full     = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_push_req = tx_fifo_writeEn & ~r_wen_d;
    assign w_push     = w_push_req & ~w_full;

    always_ff @(posedge pclk or posedge PRESETn) begin
        if (PRESETn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wen_d    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wen_d    <= tx_fifo_writeEn;
            r_overflow <= w_push_req & w_full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage is not reset; contents are only ever read behind the pointers.
    always_ff @(posedge pclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= tx_fifo_dataIn;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [CNT_W-1:0] w_baud_cnt_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_nxt;
    logic [2:0]       w_bit_idx_inc;
    logic [7:0]       r_shift;
    logic             r_tx_serial;
    logic             w_tx_serial_nxt;
    logic             w_baud_done;

    assign w_bit_idx_inc = r_bit_idx + 3'd1;
    assign w_baud_done   = (r_baud_cnt == '0);

    always_ff @(posedge pclk or posedge PRESETn) begin
        if (PRESETn) begin
            r_state     <= S_IDLE;
            r_baud_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_tx_serial <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_baud_cnt  <= w_baud_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_tx_serial <= w_tx_serial_nxt;
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

    // The line level for the coming cycle is decided together with the
    // transition, so tx_serial comes straight from a flop.
    always_comb begin
        w_state_nxt     = r_state;
        w_baud_cnt_nxt  = r_baud_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_tx_serial_nxt = r_tx_serial;
        w_pop           = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx_serial_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop           = 1'b1;
                    w_state_nxt     = S_START;
                    w_baud_cnt_nxt  = BIT_RELOAD;
                    w_tx_serial_nxt = 1'b0;
                end
            end

            S_START: begin
                if (w_baud_done) begin
                    w_state_nxt     = S_DATA;
                    w_bit_idx_nxt   = 3'd0;
                    w_baud_cnt_nxt  = BIT_RELOAD;
                    w_tx_serial_nxt = r_shift[0];
                end else begin
                    w_baud_cnt_nxt  = r_baud_cnt - CNT_W'(1);
                end
            end

            S_DATA: begin
                if (w_baud_done) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt     = S_PARITY;
                        w_baud_cnt_nxt  = BIT_RELOAD;
                        w_tx_serial_nxt = ^r_shift;
`else
                        w_state_nxt     = S_STOP;
                        w_baud_cnt_nxt  = STOP_RELOAD;
                        w_tx_serial_nxt = 1'b1;
`endif
                    end else begin
                        w_bit_idx_nxt   = w_bit_idx_inc;
                        w_baud_cnt_nxt  = BIT_RELOAD;
                        w_tx_serial_nxt = r_shift[w_bit_idx_inc];
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt - CNT_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_done) begin
                    w_state_nxt     = S_STOP;
                    w_baud_cnt_nxt  = STOP_RELOAD;
                    w_tx_serial_nxt = 1'b1;
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt - CNT_W'(1);
                end
            end
`endif

            S_STOP: begin
                w_tx_serial_nxt = 1'b1;
                if (w_baud_done) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt - CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_tx_serial_nxt = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_fifo_Full  = w_full;
    assign tx_fifo_Empty = w_empty;
    assign tx_fifo_count = r_wr_ptr - r_rd_ptr;
    assign tx_overflow   = r_overflow;
    assign tx_serial     = r_tx_serial;
    assign tx_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_serializer.sv
module tb_uart_tx_fifo_serializer;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       pclk = 1'b0;
    logic       rst  = 1'b1;

    logic       wen1 = 1'b0;
    logic [7:0] din1 = 8'h00;
    logic       full1, empty1, ovf1, ser1, busy1;
    logic [2:0] cnt1;

    logic       wen2 = 1'b0;
    logic [7:0] din2 = 8'h00;
    logic       full2, empty2, ovf2, ser2, busy2;
    logic [2:0] cnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 pclk = ~pclk;

    uart_tx_fifo_serializer #(.DEPTH(4), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut1 (
        .pclk            (pclk),
        .PRESETn         (rst),
        .tx_fifo_writeEn (wen1),
        .tx_fifo_dataIn  (din1),
        .tx_fifo_Full    (full1),
        .tx_fifo_Empty   (empty1),
        .tx_fifo_count   (cnt1),
        .tx_overflow     (ovf1),
        .tx_serial       (ser1),
        .tx_busy         (busy1)
    );

    uart_tx_fifo_serializer #(.DEPTH(4), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
        .pclk            (pclk),
        .PRESETn         (rst),
        .tx_fifo_writeEn (wen2),
        .tx_fifo_dataIn  (din2),
        .tx_fifo_Full    (full2),
        .tx_fifo_Empty   (empty2),
        .tx_fifo_count   (cnt2),
        .tx_overflow     (ovf2),
        .tx_serial       (ser2),
        .tx_busy         (busy2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Expected line level for bit position i of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0)                  return 1'b0;
        else if (i <= 8)             return b[i-1];
        else if (i == 9 && PAR == 1) return ^b;
        else                         return 1'b1;
    endfunction

    // Checks frame cycles start_c..end on the selected DUT, starting at the
    // current sample point; returns at the first cycle after the frame.
    task automatic check_frame(input int sel, input logic [7:0] b, input int start_c, input string tag);
        int nb;
        nb = 9 + PAR + ((sel == 1) ? 2 : 1);
        for (int c = start_c; c < nb * CPB; c++) begin
            chk($sformatf("%s_ser_c%0d", tag, c), (sel == 1) ? ser2 : ser1, frame_bit(b, c / CPB));
            chk($sformatf("%s_busy_c%0d", tag, c), (sel == 1) ? busy2 : busy1, 1);
            tick();
        end
        chk($sformatf("%s_end_busy", tag), (sel == 1) ? busy2 : busy1, 0);
        chk($sformatf("%s_end_ser", tag), (sel == 1) ? ser2 : ser1, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        logic saw;
        logic [7:0] ovf_bytes [6];
        ovf_bytes = '{8'h11, 8'h22, 8'h4B, 8'h96, 8'hC3, 8'h5A};

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_ser",   ser1,   1);
        chk("rst_empty", empty1, 1);
        chk("rst_full",  full1,  0);
        chk("rst_cnt",   cnt1,   0);
        chk("rst_busy",  busy1,  0);
        chk("rst_ovf",   ovf1,   0);
        chk("rst_ser2",  ser2,   1);
        rst = 1'b0;
        tick();

        // ---------------- single frame 0xA5 ----------------
        wen1 = 1'b1; din1 = 8'hA5;
        tick();
        chk("a5_push_cnt",   cnt1,   1);
        chk("a5_push_empty", empty1, 0);
        chk("a5_push_ser",   ser1,   1);
        chk("a5_push_busy",  busy1,  0);
        wen1 = 1'b0;
        tick();
        chk("a5_pop_empty", empty1, 1);
        chk("a5_pop_cnt",   cnt1,   0);
        check_frame(0, 8'hA5, 0, "a5");

`ifdef UART_TX_PARITY_EN
        // ---------------- parity: 0x07 gives parity 1 ----------------
        wen1 = 1'b1; din1 = 8'h07;
        tick();
        wen1 = 1'b0;
        tick();
        check_frame(0, 8'h07, 0, "p07");
`endif

        // ---------------- held writeEn ----------------
        wen1 = 1'b1; din1 = 8'h3C;
        tick();
        chk("held_cnt1", cnt1, 1);
        tick();
        chk("held_cnt_pop", cnt1, 0);
        chk("held_ser0",    ser1, 0);
        tick();
        chk("held_cnt_3rd", cnt1, 0);
        wen1 = 1'b0;
        check_frame(0, 8'h3C, 1, "held");
        saw = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (busy1 !== 1'b0 || ser1 !== 1'b1 || cnt1 !== 3'd0) saw = 1'b1;
            tick();
        end
        chk("held_no_second_frame", saw, 0);

        // ---------------- overflow ----------------
        for (int k = 0; k < 6; k++) begin
            wen1 = 1'b1; din1 = ovf_bytes[k];
            tick();
            case (k)
                0: chk("ovf_cnt_b1", cnt1, 1);
                1: chk("ovf_cnt_b2", cnt1, 1);
                2: chk("ovf_cnt_b3", cnt1, 2);
                3: chk("ovf_cnt_b4", cnt1, 3);
                4: begin
                    chk("ovf_cnt_b5",  cnt1,  4);
                    chk("ovf_full_b5", full1, 1);
                    chk("ovf_pulse_pre", ovf1, 0);
                end
                default: begin
                    chk("ovf_pulse",   ovf1, 1);
                    chk("ovf_cnt_b6",  cnt1, 4);
                end
            endcase
            wen1 = 1'b0;
            tick();
        end
        chk("ovf_pulse_end", ovf1, 0);
        chk("ovf_cnt_after", cnt1, 4);
        n = 0;
        while (busy1 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("ovf_wait_frame1", busy1, 0);
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("ovf_idle_%0d", k), ser1, 1);
            tick();
            check_frame(0, ovf_bytes[k], 0, $sformatf("ovf_f%0d", k + 1));
        end
        chk("ovf_drained_empty", empty1, 1);
        chk("ovf_drained_cnt",   cnt1,   0);
        tick();
        chk("ovf_no_6th_frame", busy1, 0);

        // ---------------- back-to-back, two stop bits ----------------
        wen2 = 1'b1; din2 = 8'h00;
        tick();
        chk("b2b_cnt1", cnt2, 1);
        wen2 = 1'b0;
        tick();
        chk("b2b_ser0", ser2, 0);
        wen2 = 1'b1; din2 = 8'hFF;
        tick();
        chk("b2b_cnt2", cnt2, 1);
        wen2 = 1'b0;
        check_frame(1, 8'h00, 1, "b2b00");
        tick();
        check_frame(1, 8'hFF, 0, "b2bFF");
        chk("b2b_empty", empty2, 1);

        // ---------------- reset mid-frame ----------------
        wen1 = 1'b1; din1 = 8'h65;
        tick();
        wen1 = 1'b0;
        tick();
        wen1 = 1'b1; din1 = 8'h81;
        tick();
        wen1 = 1'b0;
        tick();
        wen1 = 1'b1; din1 = 8'hE7;
        tick();
        wen1 = 1'b0;
        tick();
        chk("mid_cnt_queued", cnt1, 2);
        repeat (13) tick();
        chk("mid_ser_bit3", ser1, frame_bit(8'h65, 4));
        rst = 1'b1;
        #1;
        chk("mid_rst_ser",   ser1,   1);
        chk("mid_rst_empty", empty1, 1);
        chk("mid_rst_cnt",   cnt1,   0);
        chk("mid_rst_busy",  busy1,  0);
        tick();
        tick();
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (busy1 !== 1'b0 || ser1 !== 1'b1) saw = 1'b1;
        end
        chk("mid_no_frame_after", saw, 0);
        chk("mid_empty_after", empty1, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_serializer.md
Name: uart_tx_fifo_serializer

Overview:
Transmit-side UART stage fed by the APB UART interface through its tx_fifo_writeEn, tx_fifo_dataIn and tx_fifo_Full signals. Buffers bytes in a synchronous FIFO and serialises them onto tx_serial as 8N1 (or 8E1) frames at a fixed baud rate. Drives the full/empty status that the APB side uses to generate PREADY.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2
CLKS_PER_BIT, 868, pclk cycles per UART bit; minimum 2
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
pclk  input  1  clock
PRESETn  input  1  reset; asynchronous, active-high
tx_fifo_writeEn  input  1  push request; multi-cycle assertion allowed
tx_fifo_dataIn  input  8  byte to push
tx_fifo_Full  output  1  FIFO full
tx_fifo_Empty  output  1  FIFO empty
tx_fifo_count  output  clog2(DEPTH)+1  current occupancy
tx_overflow  output  1  one-cycle pulse when a push is dropped
tx_serial  output  1  UART line; idles high
tx_busy  output  1  high while a frame is in progress

Behaviour:
- Reset: PRESETn, asynchronous, active-high; clock pclk. While reset is high: FIFO pointers and count = 0, Empty = 1, Full = 0, tx_overflow = 0, tx_serial = 1, tx_busy = 0, FSM = IDLE, baud counter = 0. Reset asserted mid-frame aborts the frame immediately and discards all FIFO contents.
- Push: the block registers tx_fifo_writeEn every cycle. A push occurs only on the rising edge, i.e. writeEn = 1 and its registered value = 0. The byte is sampled on that edge. A held writeEn produces exactly one push; back-to-back pushes need writeEn to deassert for at least 1 cycle.
- Full check: Full is evaluated before any same-cycle pop. A push arriving while Full = 1 is dropped and tx_overflow pulses for 1 cycle, even if a pop occurs in that same cycle.
- Pop: happens only in IDLE when Empty = 0. A pop reads the head byte into the shift register and increments the read pointer.
  - Simultaneous push and pop (non-empty FIFO): count is unchanged.
  - Push into an empty FIFO: no pop that cycle; the byte becomes visible the next cycle.
- Pointers: clog2(DEPTH)+1 bits wide, wrap naturally. Full = (MSBs differ, rest equal); Empty = (pointers equal).
- Latency: push accepted at edge k -> pop and START entry at edge k+1 -> tx_serial = 0 after edge k+1.
- FSM:
  - IDLE: tx_serial = 1. If not empty: pop, baud counter = CLKS_PER_BIT-1, go to START.
  - START: tx_serial = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: drive shift[idx], LSB first, CLKS_PER_BIT cycles per bit. After idx 7 go to PARITY if enabled, otherwise STOP.
  - PARITY: see Optional Feature.
  - STOP: tx_serial = 1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- A queued byte starts at the earliest 1 cycle after STOP ends: IDLE lasts exactly 1 cycle between back-to-back frames.
- tx_busy = 1 in every state except IDLE.
- Bit timing: the baud counter decrements to 0, then the state/bit advances and the counter reloads. tx_serial is a registered output with no glitches.

Optional Feature:
UART_TX_PARITY_EN
- Defined: the PARITY state is inserted after DATA and drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 1 + 8 + 1 + STOP_BITS bits.
- Undefined: the PARITY state and its logic are absent. Frame = 1 + 8 + STOP_BITS bits.

Test Plan:
- Single frame: DEPTH=4, CLKS_PER_BIT=4, no parity; push 0xA5 -> tx_serial 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total). tx_busy high for 40 cycles. Empty returns to 1 one cycle after the push.
- Held writeEn: assert writeEn for 3 cycles with 0x3C -> exactly one push; count peaks at 1 and exactly one frame is sent.
- Overflow: push 6 bytes with 1-cycle gaps during the first frame -> byte 1 popped, bytes 2-5 stored, count = 4, Full = 1, byte 6 dropped with a 1-cycle tx_overflow pulse. Frames 2-5 are sent in order.
- Back-to-back: queue 0x00 then 0xFF, STOP_BITS=2 -> stop lasts 8 cycles, 1 IDLE cycle follows, then the next start bit.
- Reset mid-frame: assert PRESETn during DATA bit 3 with 2 bytes queued -> tx_serial = 1, Empty = 1, count = 0, tx_busy = 0 immediately. No frame is sent after release.
- Parity (macro defined): push 0xA5 -> parity bit 0; push 0x07 -> parity bit 1; frame length 44 cycles.
